// File: rtl/freq_meter.sv
// freq_meter: gated-window frequency counter with valid/ack result handshake
//   Define FREQ_METER_SAT_EN to make the edge counter saturate instead of wrap.
//   GATE_CYCLES : window length in clk cycles (>= 2)
//   CNT_W       : width of the edge counter and of freq
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : measurement enable; low holds the window idle
//   sig_in      : asynchronous signal under measurement
//   freq_ack    : consumer acknowledge of freq
//   freq        : rising-edge count of the last completed window
//   freq_valid  : freq holds an unacknowledged result
//   overrun     : sticky, a result was overwritten before being acknowledged
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             freq_ack,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overrun
);
    localparam int GW = $clog2(GATE_CYCLES);
    typedef enum logic {IDLE, COUNT} state_t;
    state_t           state, state_d;
    logic             s1, s2, dly, edge_det, close, acc;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt, edge_nxt;
    assign edge_det = s2 & ~dly;
`ifdef FREQ_METER_SAT_EN
    logic [CNT_W:0] sum;
    assign sum      = {1'b0, edge_cnt} + (CNT_W+1)'(edge_det);
    assign edge_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    assign edge_nxt = edge_cnt + CNT_W'(edge_det);
`endif
    // A window only closes while still enabled, so dropping en on the last cycle discards it
    assign close = (state == COUNT) && en && (gate_cnt == GW'(GATE_CYCLES - 1));
    assign acc   = freq_ack & freq_valid;
    always_comb begin
        state_d = IDLE;
        if (en) state_d = COUNT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            {s1, s2, dly} <= '0;
        end else begin
            state <= state_d;
            {s1, s2, dly} <= {sig_in, s1, s2};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (state != COUNT || !en || close) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_nxt;
        end
    end
    // edge_nxt folds in an edge on the closing cycle so it lands in the closing window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq       <= '0;
            freq_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (close) freq <= edge_nxt;
            freq_valid <= close | (freq_valid & ~acc);
            overrun    <= (close & freq_valid & ~freq_ack) | (overrun & ~acc);
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter (GATE_CYCLES=100)
module tb_freq_meter;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, freq_ack = 1'b0;
    logic       man = 1'b1, man_sig = 1'b0, gen_sig = 1'b0, en2 = 1'b0, sig2 = 1'b0;
    logic       sig_in, fv, ov, fv2, ov2;
    logic [7:0] freq;
    logic [3:0] freq2;
    int         half = 5;
    int         checks = 0, failures = 0;
    int         n;
    assign sig_in = man ? man_sig : gen_sig;
    freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .freq_ack(freq_ack),
        .freq(freq), .freq_valid(fv), .overrun(ov)
    );
    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_ovf (
        .clk(clk), .rst_n(rst_n), .en(en2), .sig_in(sig2), .freq_ack(1'b0),
        .freq(freq2), .freq_valid(fv2), .overrun(ov2)
    );
    always #5 clk = ~clk;
    initial begin : gen1
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            if (c >= half) begin
                gen_sig = ~gen_sig;
                c = 0;
            end
        end
    end
    initial forever begin
        repeat (2) @(negedge clk);
        sig2 = ~sig2;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_v(input bit second, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(second ? fv2 : fv) && cnt < 300);
        chk("valid_rise", {31'd0, second ? fv2 : fv}, 1);
    endtask
    task automatic ack1();
        freq_ack = 1'b1;
        @(negedge clk);
        freq_ack = 1'b0;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_freq", freq, 0);
        chk("rst_valid", fv, 0);
        chk("rst_overrun", ov, 0);
        rst_n = 1'b1;
        // period 10 square wave
        man = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        wait_v(1'b0, n);
        chk("first_latency", n, 101);
        chk("period_freq", freq, 10);
        chk("period_overrun", ov, 0);
        for (int k = 0; k < 2; k++) begin
            ack1();
            chk("ack_clears_valid", fv, 0);
            wait_v(1'b0, n);
            chk("window_gap", n, 99);
            chk("period_freq_n", freq, 10);
            chk("period_overrun_n", ov, 0);
        end
        // single rise landing on the last cycle of the window
        freq_ack = 1'b1;
        en = 1'b0;
        man = 1'b1;
        man_sig = 1'b0;
        @(negedge clk);
        freq_ack = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_valid", fv, 0);
        en = 1'b1;
        repeat (98) @(negedge clk);
        man_sig = 1'b1;
        wait_v(1'b0, n);
        chk("boundary_latency", n, 3);
        chk("boundary_freq", freq, 1);
        ack1();
        wait_v(1'b0, n);
        chk("boundary_next", freq, 0);
        // overrun with period 20
        freq_ack = 1'b1;
        en = 1'b0;
        @(negedge clk);
        freq_ack = 1'b0;
        man = 1'b0;
        half = 10;
        repeat (30) @(negedge clk);
        en = 1'b1;
        wait_v(1'b0, n);
        chk("ovr_first_freq", freq, 5);
        chk("ovr_first_flag", ov, 0);
        repeat (100) @(negedge clk);
        chk("ovr_freq", freq, 5);
        chk("ovr_valid", fv, 1);
        chk("ovr_flag", ov, 1);
        ack1();
        chk("ovr_ack_valid", fv, 0);
        chk("ovr_ack_flag", ov, 0);
        // ack on the closing cycle
        repeat (198) @(negedge clk);
        chk("pre_collide_valid", fv, 1);
        ack1();
        chk("collide_valid", fv, 1);
        chk("collide_overrun", ov, 0);
        chk("collide_freq", freq, 5);
        // drop en at gate_cnt 50
        ack1();
        chk("abort_pre_valid", fv, 0);
        repeat (49) @(negedge clk);
        en = 1'b0;
        repeat (150) @(negedge clk);
        chk("abort_valid", fv, 0);
        chk("abort_freq", freq, 5);
        chk("abort_overrun", ov, 0);
        en = 1'b1;
        wait_v(1'b0, n);
        chk("reenable_latency", n, 101);
        chk("reenable_freq", freq, 5);
        repeat (100) @(negedge clk);
        chk("pre_rst_overrun", ov, 1);
        // asynchronous reset mid-window
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_freq", freq, 0);
        chk("async_rst_valid", fv, 0);
        chk("async_rst_overrun", ov, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // overflow, CNT_W=4, 25 edges per window
        en2 = 1'b1;
        wait_v(1'b1, n);
`ifdef FREQ_METER_SAT_EN
        chk("overflow_freq", freq2, 15);
`else
        chk("overflow_freq", freq2, 9);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
